// File: rtl/mem_to_uart_frame_sender.sv
// ---------------------------------------------------------------------------
// mem_to_uart_frame_sender
//
// Dumps a range of a byte memory over a UART transmitter, using the same
// two-byte frame the UART-to-memory parser consumes. Each entry goes out as
// a (data, address) pair, or (address, data) when DATA_FIRST = 0.
//
// Ports
//   sys_clock        system clock
//   rst_n            asynchronous active-low reset
//   start            one-cycle dump request, only honoured while idle
//   start_addr       first address to dump (captured on accepted start)
//   count            number of entries, 0 means 256 (captured on start)
//   busy             high while a dump is in progress, including the done cycle
//   done             one-cycle pulse after the last byte has left the UART
//   mem_addr         memory read address
//   mem_rd           one-cycle memory read strobe
//   mem_data         read data, valid the cycle after mem_rd
//   tx_byte          byte for the UART, stable from transmit until sent
//   transmit         one-cycle send strobe to the UART
//   is_transmitting  UART busy flag
// ---------------------------------------------------------------------------
module mem_to_uart_frame_sender #(
    parameter int ADDR_W      = 8,   // one address byte per frame, so <= 8
    parameter int ACK_TIMEOUT = 16,
    parameter bit DATA_FIRST  = 1'b1
) (
    input  logic              sys_clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic [7:0]        tx_byte,
    output logic              transmit,
    input  logic              is_transmitting
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_SEND1,
        S_ACK1,
        S_WAIT1,
        S_SEND2,
        S_ACK2,
        S_WAIT2,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        rem_q, rem_d;      // 9 bits so a full 256-entry dump fits
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              transmit_q, transmit_d;

    // Address zero-extended to a full byte for the frame.
    logic [7:0] addr_byte;
    logic [7:0] first_byte, second_byte;

    always_comb begin
        addr_byte = '0;
        addr_byte[ADDR_W-1:0] = addr_q;
    end

    assign first_byte  = DATA_FIRST ? data_q    : addr_byte;
    assign second_byte = DATA_FIRST ? addr_byte : data_q;

    always_ff @(posedge sys_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            tmo_q      <= '0;
            data_q     <= '0;
            tx_byte_q  <= '0;
            transmit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            data_q     <= data_d;
            tx_byte_q  <= tx_byte_d;
            transmit_q <= transmit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        tmo_d      = tmo_q;
        data_d     = data_q;
        tx_byte_d  = tx_byte_q;
        transmit_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    rem_d   = (count == 8'd0) ? 9'd256 : {1'b0, count};
                    state_d = S_READ;
                end
            end

            S_READ:  state_d = S_LATCH;

            S_LATCH: begin
                data_d  = mem_data;
                state_d = S_SEND1;
            end

            // transmit is registered so it rises together with tx_byte;
            // the UART-idle check is made the cycle before it appears.
            S_SEND1: begin
                if (!is_transmitting) begin
                    tx_byte_d  = first_byte;
                    transmit_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = S_ACK1;
                end
            end

            // A UART that never raises its busy flag must not stall the dump.
            S_ACK1: begin
                if (is_transmitting || tmo_q == TMO_LAST) begin
                    state_d = S_WAIT1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_WAIT1: begin
                if (!is_transmitting) state_d = S_SEND2;
            end

            S_SEND2: begin
                if (!is_transmitting) begin
                    tx_byte_d  = second_byte;
                    transmit_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = S_ACK2;
                end
            end

            S_ACK2: begin
                if (is_transmitting || tmo_q == TMO_LAST) begin
                    state_d = S_WAIT2;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_WAIT2: begin
                if (!is_transmitting) state_d = S_NEXT;
            end

            S_NEXT: begin
                rem_d   = rem_q - 9'd1;
                addr_d  = addr_q + 1'b1;   // wraps modulo 2^ADDR_W
                state_d = (rem_q == 9'd1) ? S_DONE : S_READ;
            end

            S_DONE:  state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign mem_rd   = (state_q == S_READ);
    assign mem_addr = addr_q;
    assign tx_byte  = tx_byte_q;
    assign transmit = transmit_q;

endmodule

// File: tb/tb_mem_to_uart_frame_sender.sv
module tb_mem_to_uart_frame_sender;

    localparam int TMO = 16;
    localparam bit DF  = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_addr = '0;
    logic [7:0] count = '0;
    logic       busy, done, mem_rd, transmit, is_transmitting;
    logic [7:0] mem_addr, tx_byte;
    logic [7:0] mem_data = '0;

    mem_to_uart_frame_sender #(.ADDR_W(8), .ACK_TIMEOUT(TMO), .DATA_FIRST(DF)) dut (
        .sys_clock(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .count(count), .busy(busy), .done(done), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_data(mem_data), .tx_byte(tx_byte),
        .transmit(transmit), .is_transmitting(is_transmitting)
    );

    always #5 clk = ~clk;

    // ---------------- environment: memory + uart model ----------------
    logic [7:0] mem [256];
    int         cyc = 0;
    int         bt_cnt = 0;
    int         byte_time = 3;
    bit         silent = 1'b0;
    bit         force_busy = 1'b0;
    int         proto_err = 0;
    int         done_cnt = 0;
    logic [7:0] held = '0;
    logic [7:0] txq[$];
    int         tx_t[$];
    logic [7:0] rdq[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    assign is_transmitting = force_busy | (bt_cnt != 0);

    always @(negedge clk) begin
        if (!rst_n) begin
            bt_cnt <= 0;
        end else begin
            if (mem_rd && transmit) proto_err <= proto_err + 1;
            if (mem_rd) rdq.push_back(mem_addr);
            if (done) done_cnt <= done_cnt + 1;
            if (transmit) begin
                if (is_transmitting) proto_err <= proto_err + 1;
                txq.push_back(tx_byte);
                tx_t.push_back(cyc);
                held <= tx_byte;
                if (!silent) bt_cnt <= byte_time;
            end else if (bt_cnt != 0) begin
                if (tx_byte !== held) proto_err <= proto_err + 1;
                bt_cnt <= bt_cnt - 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] sa, input logic [7:0] cnt);
        start_addr = sa;
        count      = cnt;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Waits for done, then compares the whole dump against a frame list
    // built straight from the memory image.
    task automatic finish_dump(input string tag, input logic [7:0] sa, input logic [7:0] cnt,
                               input int tb0, input int rb0, input int db0, input int budget);
        int n, nerr, rerr;
        bit got;
        logic [7:0] a;
        logic [7:0] exp_q[$];
        n   = (cnt == 8'd0) ? 256 : int'(cnt);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_idle_at_done"}, 32'(is_transmitting), 32'd0);
        check({tag, "_tx_count"}, 32'(txq.size() - tb0), 32'(2 * n));
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt - db0), 32'd1);
        for (int i = 0; i < n; i++) begin
            a = 8'((int'(sa) + i) % 256);
            if (DF) begin exp_q.push_back(mem[a]); exp_q.push_back(a); end
            else    begin exp_q.push_back(a); exp_q.push_back(mem[a]); end
        end
        nerr = 0;
        rerr = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (tb0 + k >= txq.size() || txq[tb0 + k] !== exp_q[k]) nerr++;
        for (int i = 0; i < n; i++)
            if (rb0 + i >= rdq.size() || rdq[rb0 + i] !== 8'((int'(sa) + i) % 256)) rerr++;
        check({tag, "_bytes"}, 32'(nerr), 32'd0);
        check({tag, "_rd_addrs"}, 32'(rerr), 32'd0);
    endtask

    task automatic run_dump(input string tag, input logic [7:0] sa, input logic [7:0] cnt,
                            input int budget);
        int tb0, rb0, db0;
        tb0 = txq.size();
        rb0 = rdq.size();
        db0 = done_cnt;
        pulse_start(sa, cnt);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        finish_dump(tag, sa, cnt, tb0, rb0, db0, budget);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int tb0, rb0, db0, gap;
        logic [7:0] sa;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_transmit", 32'(transmit), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single entry
        mem[8'h10] = 8'hA5;
        byte_time  = 4;
        run_dump("single", 8'h10, 8'd1, 200);

        // address wrap
        mem[8'hFE] = 8'h11;
        mem[8'hFF] = 8'h22;
        mem[8'h00] = 8'h33;
        run_dump("wrap", 8'hFE, 8'd3, 400);

        // randomized dumps
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            byte_time = $urandom_range(1, 8);
            run_dump("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(1, 12)), 2000);
        end

        // full dump, count = 0
        byte_time = 2;
        run_dump("full", 8'h00, 8'd0, 20000);

        // uart busy at start: no transmit until it drops, extra starts ignored
        byte_time  = 3;
        force_busy = 1'b1;
        sa  = 8'($urandom_range(0, 255));
        tb0 = txq.size();
        rb0 = rdq.size();
        db0 = done_cnt;
        pulse_start(sa, 8'd2);
        check("ubusy_busy", 32'(busy), 32'd1);
        repeat (30) @(negedge clk);
        pulse_start(8'h00, 8'd5);
        repeat (5) @(negedge clk);
        pulse_start(8'h40, 8'd7);
        repeat (5) @(negedge clk);
        check("ubusy_no_tx", 32'(txq.size() - tb0), 32'd0);
        force_busy = 1'b0;
        finish_dump("ubusy", sa, 8'd2, tb0, rb0, db0, 500);
        repeat (40) @(negedge clk);
        check("ubusy_no_extra", 32'(txq.size() - tb0), 32'd4);

        // ack timeout: uart never raises its busy flag
        silent = 1'b1;
        tb0 = txq.size();
        run_dump("tmo", 8'h20, 8'd2, 1000);
        gap = tx_t[tb0 + 1] - tx_t[tb0];
        check("tmo_gap_ge", 32'(gap >= TMO), 32'd1);
        check("tmo_gap_le", 32'(gap <= TMO + 4), 32'd1);
        silent = 1'b0;

        check("protocol", 32'(proto_err), 32'd0);

        // reset in WAIT1 of frame 2
        byte_time = 6;
        tb0 = txq.size();
        pulse_start(8'h80, 8'd3);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (txq.size() - tb0 >= 3) break;
        end
        repeat (2) @(negedge clk);
        check("rst_pre_wait1", 32'(is_transmitting), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_transmit", 32'(transmit), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("midrst_no_tx", 32'(txq.size() - tb0), 32'd3);
        check("midrst_idle", 32'(busy), 32'd0);

        // dump works again after reset
        byte_time = 2;
        run_dump("post_rst", 8'h05, 8'd2, 500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
